// File: rtl/store_buffer.sv
// store_buffer: doubleword store FIFO between the core's store port and the
// data-memory port, with load forwarding from held entries.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   st_valid/st_addr/st_data      store request from core
//   st_stall                      buffer full, core must hold its store
//   ld_addr                       load address checked against held stores
//   fwd_hit/fwd_data              youngest matching entry (data 0 on miss)
//   mem_valid/mem_ready           head entry handshake to memory
//   mem_addr/mem_data/mem_strb    head entry contents, strobes 8'hFF when valid
//   empty, count                  occupancy
//   misalign_err                  sticky flag: a misaligned store was dropped

// One buffer slot: holds a store and reports whether it covers the load's
// doubleword. Occupancy is tracked by the parent via head/count.
module sb_entry #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] ld_addr,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          match
);
  // Contents need no reset: the parent never reads a slot it has not written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr <= wr_addr;
      data <= wr_data;
    end
  end

  // Low three bits are the byte offset within the doubleword.
  assign match = (ld_addr[AW-1:3] == addr[AW-1:3]);
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 64,
  parameter int DW    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  output logic                       st_stall,
  input  logic [AW-1:0]              ld_addr,
  output logic                       fwd_hit,
  output logic [DW-1:0]              fwd_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_data,
  output logic [7:0]                 mem_strb,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       misalign_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head, tail;
  logic          full, enq, deq, misal;

  logic [DEPTH-1:0]         ent_we;
  logic [DEPTH-1:0]         ent_match;
  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0][DW-1:0] ent_data;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign st_stall = full;

  // A full buffer ignores the store outright, even if the head drains this
  // cycle; the core simply retries while st_stall is high.
  assign enq   = st_valid && !full && (st_addr[2:0] == 3'b000);
  assign misal = st_valid && !full && (st_addr[2:0] != 3'b000);

  assign mem_valid = !empty;
  assign deq       = mem_valid && mem_ready;
  assign mem_addr  = ent_addr[head];
  assign mem_data  = ent_data[head];
  assign mem_strb  = mem_valid ? 8'hFF : 8'h00;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      assign ent_we[g] = enq && (tail == PW'(g));
      sb_entry #(.AW(AW), .DW(DW)) u_ent (
        .clk     (clk),
        .wr_en   (ent_we[g]),
        .wr_addr (st_addr),
        .wr_data (st_data),
        .ld_addr (ld_addr),
        .addr    (ent_addr[g]),
        .data    (ent_data[g]),
        .match   (ent_match[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (misal) misalign_err <= 1'b1;
    end
  end

  // Walk held entries oldest to youngest so the last match seen is the
  // youngest. Only the registered count gates visibility, so a store being
  // enqueued this cycle is not seen and a head being popped still is.
  logic [PW-1:0] idx;
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && ent_match[idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_stall;
  logic [AW-1:0] ld_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [7:0]    mem_strb;
  logic          empty;
  logic [$clog2(DEPTH):0] count;
  logic          misalign_err;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall),
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_strb(mem_strb),
    .empty(empty), .count(count), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [63:0] a, input logic [63:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_addr = '0; mem_ready = 1'b0;
    tick; tick;

    // Reset state
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_mvalid", 64'(mem_valid), 64'd0);
    chk("rst_strb", 64'(mem_strb), 64'h00);
    chk("rst_stall", 64'(st_stall), 64'd0);
    chk("rst_fwd", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_data", fwd_data, 64'd0);
    chk("rst_mis", 64'(misalign_err), 64'd0);
    rst = 1'b0;

    // Single store
    mem_ready = 1'b1;
    st(64'h8000_0010, 64'h1122_3344_5566_7788);
    ld_addr = 64'h8000_0010;
    #1 chk("single_nofwd_same_cycle", 64'(fwd_hit), 64'd0);
    tick;
    st_valid = 1'b0;
    chk("single_mvalid", 64'(mem_valid), 64'd1);
    chk("single_maddr", mem_addr, 64'h8000_0010);
    chk("single_mdata", mem_data, 64'h1122_3344_5566_7788);
    chk("single_strb", 64'(mem_strb), 64'hFF);
    chk("single_fwd", 64'(fwd_hit), 64'd1);
    chk("single_fwd_data", fwd_data, 64'h1122_3344_5566_7788);
    tick;
    chk("single_empty", 64'(empty), 64'd1);
    chk("single_count", 64'(count), 64'd0);

    // Fill and stall
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      st(64'h100 + 64'(8 * k), 64'hD0 + 64'(k));
      tick;
    end
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_stall", 64'(st_stall), 64'd1);
    st(64'h120, 64'hD4);
    tick;
    chk("fill_5th_rejected", 64'(count), 64'd4);
    chk("fill_head", mem_addr, 64'h100);
    mem_ready = 1'b1;
    tick;  // pop 0x100; 5th still ignored because buffer was full
    chk("full_deq_count", 64'(count), 64'd3);
    chk("full_deq_stall", 64'(st_stall), 64'd0);
    chk("drain_0", mem_addr, 64'h108);
    tick;  // pop 0x108, enqueue 0x120
    st_valid = 1'b0;
    chk("drain_1", mem_addr, 64'h110);
    chk("drain_1_count", 64'(count), 64'd3);
    tick;
    chk("drain_2", mem_addr, 64'h118);
    chk("drain_2_count", 64'(count), 64'd2);
    tick;
    chk("drain_3", mem_addr, 64'h120);
    chk("drain_3_data", mem_data, 64'hD4);
    tick;
    chk("drain_empty", 64'(empty), 64'd1);

    // Backpressure hold
    mem_ready = 1'b0;
    st(64'h200, 64'hAA);
    tick;
    st_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_addr", mem_addr, 64'h200);
      chk("hold_data", mem_data, 64'hAA);
      chk("hold_strb", 64'(mem_strb), 64'hFF);
      tick;
    end
    mem_ready = 1'b1;
    tick;
    chk("hold_popped", 64'(empty), 64'd1);

    // Forwarding: youngest match wins, offset bits ignored
    mem_ready = 1'b0;
    st(64'h300, 64'h1); tick;
    st(64'h300, 64'h2); tick;
    st_valid = 1'b0;
    ld_addr = 64'h304;
    #1 chk("fwd_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_youngest", fwd_data, 64'h2);
    ld_addr = 64'h308;
    #1 chk("fwd_miss", 64'(fwd_hit), 64'd0);
    chk("fwd_miss_data", fwd_data, 64'd0);
    mem_ready = 1'b1;
    tick; tick;
    chk("fwd_drained", 64'(empty), 64'd1);

    // Misaligned store, then 10 stores across pointer wrap
    mem_ready = 1'b0;
    st(64'h403, 64'hBAD);
    tick;
    st_valid = 1'b0;
    chk("mis_err", 64'(misalign_err), 64'd1);
    chk("mis_count", 64'(count), 64'd0);
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      st(64'h500 + 64'(8 * k), 64'hC00 + 64'(k));
      tick;
      chk("wrap_addr", mem_addr, 64'h500 + 64'(8 * k));
      chk("wrap_data", mem_data, 64'hC00 + 64'(k));
      chk("wrap_count", 64'(count), 64'd1);
    end
    st_valid = 1'b0;
    tick;
    chk("wrap_empty", 64'(empty), 64'd1);
    chk("mis_sticky", 64'(misalign_err), 64'd1);

    // Reset mid-operation
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st(64'h600 + 64'(8 * k), 64'(k)); tick;
    end
    st_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd3);
    mem_ready = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    mem_ready = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_empty", 64'(empty), 64'd1);
    chk("mid_rst_mvalid", 64'(mem_valid), 64'd0);
    chk("mid_rst_mis", 64'(misalign_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
